alu_serial: RTL and testbench
=============================

# alu_serial

Parametrised, multi-cycle successor to the 8-bit slice-chained ALU. One operation runs WIDTH/SLICE cycles through a single reusable SLICE-bit datapath, with the carry held in a register between passes instead of rippling through replicated slices. Valid/ready handshakes on input and output let it sit between a register-file read stage and a writeback stage. It adds a subtract mode and optional carry/zero/overflow flags.

## Interface
- WIDTH, 8: operand/result width; must be a multiple of SLICE.
- SLICE, 1: bits processed per cycle. N = WIDTH/SLICE passes per operation.

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- mode  in  3  operation: 000 add, 001 AND, 010 OR, 011 XOR, 100 XNOR, 101 sub (A−B), 110/111 reserved
- a, b  in  WIDTH  operands
- in_valid  in  1  operands/mode valid
- in_ready  out  1  block idle; high exactly in IDLE
- x  out  WIDTH  result, stable while out_valid
- out_valid  out  1  result available
- out_ready  in  1  consumer accepts result
- carry, zero, ovf  out  1 each  flags, stable while out_valid (see Configuration)

## Operation
- FSM states: IDLE → RUN → DONE → IDLE.
- IDLE: in_ready=1. On an edge with in_valid&in_ready, mode/a/b are latched into shift registers, cnt=0, carry_reg = (mode==sub), and the FSM goes to RUN. in_valid without acceptance has no effect.
- RUN: each edge feeds the low SLICE bits of A and B to alu_slice. The result slice shifts in at the top of x_sh, A/B shift right by SLICE, carry_reg takes the slice carry-out, and cnt increments. At cnt==N−1 the FSM goes to DONE.
- sub: B is inverted per slice, carry-in 1. carry=1 means no borrow.
- Logic modes: carry-out forced 0. Reserved modes: slice result 0, carry 0; the operation still takes N cycles.
- DONE: out_valid=1; x and flags held. The edge with out_ready=1 returns the FSM to IDLE. in_ready=0 until then; no overlap of operations.
- Flags latched on the last RUN edge:
  - carry = final carry_reg.
  - zero = (result == 0).
  - ovf, add/sub only: (a_msb == b'_msb) && (res_msb != a_msb), where b' is the post-inversion operand; ovf=0 otherwise.
- Reset (any state, including mid-RUN): FSM→IDLE, out_valid=0, x=0, carry/zero/ovf=0, cnt=0, shift registers=0. The in-flight operation is dropped.

## Timing
- Acceptance edge E0. RUN edges E1..EN. out_valid is high from after EN. Latency is N cycles from the acceptance edge to out_valid.
- Best-case throughput: one operation per N+2 cycles (accept, N RUN, one DONE cycle with out_ready=1).
- in_ready is combinational from state. While rst_n is low it reads 1, but inputs are not sampled.
- out_valid never drops without an out_ready handshake, except on reset.

## Configuration
- ALU_SERIAL_FLAGS_EN defined: carry/zero/ovf registers and logic are built as above.
- Undefined: the flag ports remain and are tied 0; no flag registers are built. x and the handshakes are unchanged.

## Structure
- Package alu_pkg holds:
  - the mode encoding typedef (alu_mode_t: ADD, AND, OR, XOR, XNOR, SUB);
  - the FSM state typedef;
  - a localparam check that WIDTH % SLICE == 0 (elaboration error otherwise).
- Sub-module alu_slice: combinational, SLICE bits wide. Inputs mode, a, b, cin. Outputs y, cout, and the MSB operands used for ovf. One instance only.

## Test plan
- WIDTH=8, SLICE=1, add 0xFF+0x01 → x=0x00, carry=1, zero=1, ovf=0; out_valid exactly 8 cycles after acceptance edge.
- WIDTH=8, SLICE=4, sub 0x10−0x01 → x=0x0F, carry=1, ovf=0; then add 0x7F+0x01 → x=0x80, ovf=1, carry=0.
- XNOR 0xF0,0xCC → x=0xC3, carry=0; AND 0xF0,0xCC → 0xC0; mode 111 → x=0x00, zero=1.
- Backpressure: out_ready low 5 cycles in DONE → x/flags/out_valid held, in_ready=0, a held in_valid is not accepted. out_ready=1 → IDLE next cycle, then that operand accepted.
- rst_n pulsed low at RUN edge E3 → out_valid=0, x=0, in_ready=1 immediately. A following add 0x12+0x34 → 0x46 with normal latency.
- Without ALU_SERIAL_FLAGS_EN: the 0xFF+0x01 case gives x=0x00 and carry/zero/ovf all 0.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared types and configuration helpers for the serial ALU.
package alu_pkg;

  typedef enum logic [2:0] {
    MODE_ADD  = 3'b000,
    MODE_AND  = 3'b001,
    MODE_OR   = 3'b010,
    MODE_XOR  = 3'b011,
    MODE_XNOR = 3'b100,
    MODE_SUB  = 3'b101
  } alu_mode_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } alu_state_t;

  localparam int unsigned ALU_DEFAULT_WIDTH = 8;
  localparam int unsigned ALU_DEFAULT_SLICE = 1;

  // The datapath needs a whole number of passes per operation.
  function automatic bit alu_cfg_ok(input int unsigned width, input int unsigned slice);
    return (slice != 0) && (width >= slice) && ((width % slice) == 0);
  endfunction

endpackage

// File: rtl/alu_slice.sv
// Combinational SLICE-bit ALU datapath reused on every pass of alu_serial.
module alu_slice
  import alu_pkg::*;
#(
  parameter int unsigned SLICE = ALU_DEFAULT_SLICE
) (
  input  logic [2:0]       mode,
  input  logic [SLICE-1:0] a,
  input  logic [SLICE-1:0] b,
  input  logic             cin,
  output logic [SLICE-1:0] y,
  output logic             cout,
  output logic             a_msb,
  output logic             b_msb
);

  localparam int unsigned SW = SLICE + 1;

  logic [SLICE-1:0] b_eff;
  logic [SW-1:0]    sum;

  // Subtract is add of the inverted operand; carry-in is seeded by the caller.
  always_comb begin
    b_eff = (mode == MODE_SUB) ? ~b : b;
    sum   = SW'(a) + SW'(b_eff) + SW'(cin);
    y     = '0;
    cout  = 1'b0;
    case (mode)
      MODE_ADD, MODE_SUB: begin
        y    = sum[SLICE-1:0];
        cout = sum[SLICE];
      end
      MODE_AND:  y = a & b;
      MODE_OR:   y = a | b;
      MODE_XOR:  y = a ^ b;
      MODE_XNOR: y = ~(a ^ b);
      default:   y = '0;
    endcase
    a_msb = a[SLICE-1];
    b_msb = b_eff[SLICE-1];
  end

endmodule

// File: rtl/alu_serial.sv
// Multi-cycle ALU: WIDTH/SLICE passes through one alu_slice with a registered carry.
// Define ALU_SERIAL_FLAGS_EN to build the carry/zero/ovf flag registers.
module alu_serial
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = ALU_DEFAULT_WIDTH,
  parameter int unsigned SLICE = ALU_DEFAULT_SLICE
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] x,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             carry,
  output logic             zero,
  output logic             ovf
);

  localparam int unsigned N     = WIDTH / SLICE;
  localparam int unsigned CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam bit          CFG_OK = alu_cfg_ok(WIDTH, SLICE);

  if (!CFG_OK) begin : g_bad_cfg
    $error("alu_serial: WIDTH must be a non-zero multiple of SLICE");
  end

  alu_state_t             state_q, state_d;
  logic [CNT_W-1:0]       cnt_q;
  logic [2:0]             mode_q;
  logic [WIDTH-1:0]       a_sh_q, b_sh_q, x_sh_q, x_sh_d;
  logic [WIDTH+SLICE-1:0] x_cat;
  logic                   carry_reg_q, out_valid_q;
  logic                   accept, last_pass;
  logic [SLICE-1:0]       slice_y;
  logic                   slice_cout, slice_a_msb, slice_b_msb;

  assign accept    = in_valid && in_ready;
  assign last_pass = (state_q == ST_RUN) && (cnt_q == CNT_W'(N - 1));
  // New slice enters at the top so the LSB slice lands at bit 0 after N passes.
  assign x_cat     = {slice_y, x_sh_q};
  assign x_sh_d    = x_cat[WIDTH+SLICE-1:SLICE];
  assign x         = x_sh_q;
  assign out_valid = out_valid_q;

  alu_slice #(.SLICE(SLICE)) u_slice (
    .mode  (mode_q),
    .a     (a_sh_q[SLICE-1:0]),
    .b     (b_sh_q[SLICE-1:0]),
    .cin   (carry_reg_q),
    .y     (slice_y),
    .cout  (slice_cout),
    .a_msb (slice_a_msb),
    .b_msb (slice_b_msb)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (in_valid)  state_d = ST_RUN;
      ST_RUN:  if (last_pass) state_d = ST_DONE;
      ST_DONE: if (out_ready) state_d = ST_IDLE;
      default:                state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    in_ready = 1'b0;
    if (state_q == ST_IDLE) in_ready = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q       <= '0;
      mode_q      <= '0;
      a_sh_q      <= '0;
      b_sh_q      <= '0;
      x_sh_q      <= '0;
      carry_reg_q <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      if (accept) begin
        mode_q      <= mode;
        a_sh_q      <= a;
        b_sh_q      <= b;
        cnt_q       <= '0;
        carry_reg_q <= (mode == MODE_SUB);
      end else if (state_q == ST_RUN) begin
        a_sh_q      <= a_sh_q >> SLICE;
        b_sh_q      <= b_sh_q >> SLICE;
        x_sh_q      <= x_sh_d;
        carry_reg_q <= slice_cout;
        cnt_q       <= cnt_q + CNT_W'(1);
      end
      if (last_pass)                            out_valid_q <= 1'b1;
      else if ((state_q == ST_DONE) && out_ready) out_valid_q <= 1'b0;
    end
  end

`ifdef ALU_SERIAL_FLAGS_EN
  logic carry_q, zero_q, ovf_q;
  logic is_arith;

  assign is_arith = (mode_q == MODE_ADD) || (mode_q == MODE_SUB);

  // The last pass sees the MSB slice, so signed overflow is decided here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      carry_q <= 1'b0;
      zero_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else if (last_pass) begin
      carry_q <= slice_cout;
      zero_q  <= (x_sh_d == '0);
      ovf_q   <= is_arith && (slice_a_msb == slice_b_msb) &&
                 (slice_y[SLICE-1] != slice_a_msb);
    end
  end

  assign carry = carry_q;
  assign zero  = zero_q;
  assign ovf   = ovf_q;
`else
  logic flags_unused;
  assign flags_unused = slice_a_msb ^ slice_b_msb;
  assign carry = 1'b0;
  assign zero  = 1'b0;
  assign ovf   = 1'b0;
`endif

endmodule

// File: tb/tb_alu_serial.sv
// Scoreboard bench for alu_serial: two instances (SLICE=1 and SLICE=4) on shared operands.
`timescale 1ns/1ps
module tb_alu_serial;
  import alu_pkg::*;

  typedef struct packed {
    logic [7:0] x;
    logic       c;
    logic       z;
    logic       v;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] mode = 3'b000;
  logic [7:0] a = 8'h00;
  logic [7:0] b = 8'h00;
  logic       iv1 = 1'b0, iv4 = 1'b0;
  logic       ordy = 1'b1;
  logic       rdy1, rdy4, ov1, ov4;
  logic [7:0] x1, x4;
  logic       c1, z1, o1, c4, z4, o4;

  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  int   acc1 = 0, acc4 = 0;
  logic ov1_prev = 1'b0, ov4_prev = 1'b0;
  exp_t q1[$];
  exp_t q4[$];
  exp_t e1, e4;

  alu_serial #(.WIDTH(8), .SLICE(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .mode(mode), .a(a), .b(b),
    .in_valid(iv1), .in_ready(rdy1), .x(x1), .out_valid(ov1),
    .out_ready(ordy), .carry(c1), .zero(z1), .ovf(o1)
  );

  alu_serial #(.WIDTH(8), .SLICE(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .mode(mode), .a(a), .b(b),
    .in_valid(iv4), .in_ready(rdy4), .x(x4), .out_valid(ov4),
    .out_ready(ordy), .carry(c4), .zero(z4), .ovf(o4)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int got, input int req);
    checks++;
    if (got != req) begin
      failures++;
      $display("FAIL %s: got 0x%0h required 0x%0h (t=%0t)", name, got, req, $time);
    end
  endtask

  function automatic exp_t mk(input logic [7:0] xv, input logic cv, input logic zv, input logic vv);
    exp_t r;
    r.x = xv;
`ifdef ALU_SERIAL_FLAGS_EN
    r.c = cv; r.z = zv; r.v = vv;
`else
    r.c = 1'b0; r.z = 1'b0; r.v = 1'b0;
    if (cv ^ zv ^ vv) r.x = xv;
`endif
    return r;
  endfunction

  task automatic compare_out(input string who, input logic [7:0] xv, input logic cv,
                             input logic zv, input logic vv, input exp_t e);
    check({who, " x"},     int'(xv), int'(e.x));
    check({who, " carry"}, int'(cv), int'(e.c));
    check({who, " zero"},  int'(zv), int'(e.z));
    check({who, " ovf"},   int'(vv), int'(e.v));
  endtask

  // Monitors: sampled mid-low-phase, after the driver has settled its inputs.
  always begin
    @(negedge clk); #2;
    if (!rst_n) ov1_prev = 1'b0;
    else begin
      if (ov1 && !ov1_prev) check("dut1 latency", cyc - acc1, 8);
      ov1_prev = ov1;
      if (ov1 && ordy) begin
        check("dut1 expected pending", int'(q1.size() != 0), 1);
        if (q1.size() != 0) begin
          e1 = q1.pop_front();
          compare_out("dut1", x1, c1, z1, o1, e1);
        end
      end
    end
  end

  always begin
    @(negedge clk); #2;
    if (!rst_n) ov4_prev = 1'b0;
    else begin
      if (ov4 && !ov4_prev) check("dut4 latency", cyc - acc4, 2);
      ov4_prev = ov4;
      if (ov4 && ordy) begin
        check("dut4 expected pending", int'(q4.size() != 0), 1);
        if (q4.size() != 0) begin
          e4 = q4.pop_front();
          compare_out("dut4", x4, c4, z4, o4, e4);
        end
      end
    end
  end

  // Called at a falling edge with iv1/iv4 raised; returns at the falling edge after the last acceptance.
  task automatic wait_accept();
    logic p1, p4;
    for (int t = 0; t < 200 && (iv1 || iv4); t++) begin
      p1 = iv1 && rdy1;
      p4 = iv4 && rdy4;
      if (p1) acc1 = cyc + 1;
      if (p4) acc4 = cyc + 1;
      @(posedge clk);
      @(negedge clk);
      if (p1) iv1 = 1'b0;
      if (p4) iv4 = 1'b0;
    end
    check("accept timeout", int'(iv1 || iv4), 0);
    iv1 = 1'b0;
    iv4 = 1'b0;
  endtask

  task automatic issue(input logic [2:0] m, input logic [7:0] aa, input logic [7:0] bb,
                       input exp_t e, input bit to1, input bit to4);
    if (to1) q1.push_back(e);
    if (to4) q4.push_back(e);
    mode = m; a = aa; b = bb;
    iv1 = 1'b1; iv4 = 1'b1;
    wait_accept();
  endtask

  task automatic wait_idle();
    for (int t = 0; t < 100 && !(rdy1 && rdy4); t++) @(negedge clk);
    check("idle timeout", int'(rdy1 && rdy4), 1);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check("reset rdy1", int'(rdy1), 1);
    check("reset ov1",  int'(ov1), 0);
    check("reset x1",   int'(x1), 0);
    check("reset flags1", int'({c1, z1, o1}), 0);
    check("reset rdy4", int'(rdy4), 1);
    check("reset ov4",  int'(ov4), 0);
    rst_n = 1'b1;
    @(negedge clk);

    issue(3'(MODE_ADD),  8'hFF, 8'h01, mk(8'h00, 1'b1, 1'b1, 1'b0), 1, 1);
    issue(3'(MODE_SUB),  8'h10, 8'h01, mk(8'h0F, 1'b1, 1'b0, 1'b0), 1, 1);
    issue(3'(MODE_ADD),  8'h7F, 8'h01, mk(8'h80, 1'b0, 1'b0, 1'b1), 1, 1);
    issue(3'(MODE_XNOR), 8'hF0, 8'hCC, mk(8'hC3, 1'b0, 1'b0, 1'b0), 1, 1);
    issue(3'(MODE_AND),  8'hF0, 8'hCC, mk(8'hC0, 1'b0, 1'b0, 1'b0), 1, 1);
    issue(3'b111,        8'hA5, 8'h5A, mk(8'h00, 1'b0, 1'b1, 1'b0), 1, 1);
    issue(3'(MODE_SUB),  8'h05, 8'h07, mk(8'hFE, 1'b0, 1'b0, 1'b0), 1, 1);
    issue(3'(MODE_SUB),  8'h80, 8'h01, mk(8'h7F, 1'b1, 1'b0, 1'b1), 1, 1);
    issue(3'b110,        8'hFF, 8'hFF, mk(8'h00, 1'b0, 1'b1, 1'b0), 1, 1);

    // Backpressure: result must hold and a pending operand must wait.
    wait_idle();
    ordy = 1'b0;
    issue(3'(MODE_OR), 8'hA0, 8'h05, mk(8'hA5, 1'b0, 1'b0, 1'b0), 1, 1);
    for (int t = 0; t < 100 && !(ov1 && ov4); t++) @(negedge clk);
    check("done timeout", int'(ov1 && ov4), 1);
    q1.push_back(mk(8'hC3, 1'b0, 1'b0, 1'b0));
    q4.push_back(mk(8'hC3, 1'b0, 1'b0, 1'b0));
    mode = 3'(MODE_XOR); a = 8'h3C; b = 8'hFF;
    iv1 = 1'b1; iv4 = 1'b1;
    repeat (5) begin
      @(negedge clk);
      check("hold ov1",  int'(ov1), 1);
      check("hold x1",   int'(x1), 8'hA5);
      check("hold rdy1", int'(rdy1), 0);
      check("hold z1",   int'(z1), 0);
      check("hold ov4",  int'(ov4), 1);
      check("hold x4",   int'(x4), 8'hA5);
      check("hold rdy4", int'(rdy4), 0);
    end
    ordy = 1'b1;
    @(negedge clk);
    check("idle after handshake rdy1", int'(rdy1), 1);
    check("idle after handshake rdy4", int'(rdy4), 1);
    wait_accept();

    // Reset at RUN edge E3 of the SLICE=1 instance drops its operation.
    wait_idle();
    issue(3'(MODE_ADD), 8'h55, 8'h11, mk(8'h66, 1'b0, 1'b0, 1'b0), 0, 1);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("rst ov1",   int'(ov1), 0);
    check("rst x1",    int'(x1), 0);
    check("rst rdy1",  int'(rdy1), 1);
    check("rst flags1", int'({c1, z1, o1}), 0);
    check("rst rdy4",  int'(rdy4), 1);
    check("rst x4",    int'(x4), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    issue(3'(MODE_ADD), 8'h12, 8'h34, mk(8'h46, 1'b0, 1'b0, 1'b0), 1, 1);

    for (int t = 0; t < 200 && (q1.size() != 0 || q4.size() != 0); t++) @(negedge clk);
    check("dut1 drained", q1.size(), 0);
    check("dut4 drained", q4.size(), 0);
    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

endmodule
